// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, FSM encoding and accumulator sizing for mac_seq
package mac_pkg;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  function automatic int acc_w(input int dw, input int vec_len);
    return 2 * (dw - 1) + $clog2(vec_len);
  endfunction
endpackage

// File: rtl/mac_lane_sum.sv
// mac_lane_sum: combinational per-beat positive/negative sums of sign-magnitude lane products
module mac_lane_sum #(
  parameter int DW = 8,
  parameter int LANES = 4,
  localparam int PW = 2 * (DW - 1),
  localparam int SW = PW + $clog2(LANES)
) (
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] w,
  input  logic [LANES-1:0]    en,
  output logic [SW-1:0]       pos,
  output logic [SW-1:0]       neg
);
  logic [SW-1:0] p [LANES];
  logic [LANES-1:0] s;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign p[k] = en[k] ? SW'(PW'(a[k*DW +: DW-1]) * PW'(w[k*DW +: DW-1])) : '0;
    assign s[k] = a[k*DW+DW-1] ^ w[k*DW+DW-1];
  end
  always_comb begin
    pos = '0;
    neg = '0;
    for (int k = 0; k < LANES; k++) begin
      pos = pos + (s[k] ? '0 : p[k]);
      neg = neg + (s[k] ? p[k] : '0);
    end
  end
endmodule

// File: rtl/mac_seq.sv
// mac_seq: pipelined sign-magnitude dot-product MAC with valid/ready handshake
// Define MAC_SEQ_RELU_EN to clamp negative results to zero.
module mac_seq import mac_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int VEC_LEN = 62,
  parameter int LANES = 4,
  localparam int BEATS = (VEC_LEN + LANES - 1) / LANES,
  localparam int ACC_W = acc_w(DW, VEC_LEN),
  localparam int OUT_W = ACC_W + 1,
  localparam int SW = 2 * (DW - 1) + $clog2(LANES),
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] a_in,
  input  logic [LANES*DW-1:0] w_in,
  output logic [OUT_W-1:0]    out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);
  state_t state;
  logic [ACC_W-1:0] pos_acc, neg_acc, np, nn;
  logic [CW-1:0] beat_cnt;
  logic [LANES-1:0] en;
  logic [SW-1:0] lp, ln;
  logic [OUT_W-1:0] res;
  always_comb begin
    en = '0;
    for (int k = 0; k < LANES; k++) en[k] = (int'(beat_cnt) * LANES + k) < VEC_LEN;
  end
  mac_lane_sum #(.DW(DW), .LANES(LANES)) u_lane (.a(a_in), .w(w_in), .en(en), .pos(lp), .neg(ln));
  assign np = pos_acc + ACC_W'(lp);
  assign nn = neg_acc + ACC_W'(ln);
`ifdef MAC_SEQ_RELU_EN
  assign res = np > nn ? {1'b0, np - nn} : '0;
`else
  assign res = np > nn ? {1'b0, np - nn} : np < nn ? {1'b1, nn - np} : '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pos_acc <= '0;
      neg_acc <= '0;
      beat_cnt <= '0;
      out <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          pos_acc <= '0;
          neg_acc <= '0;
          beat_cnt <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        ACCUM: if (in_valid) begin
          pos_acc <= np;
          neg_acc <= nn;
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == CW'(BEATS - 1)) begin
            state <= DONE;
            out <= res;
            in_ready <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: randomized directed bench for mac_seq against a signed-integer dot-product model
module tb_mac_seq;
  localparam int DW = 8, VEC_LEN = 62, LANES = 4;
  localparam int BEATS = (VEC_LEN + LANES - 1) / LANES;
  localparam int ACC_W = 2 * (DW - 1) + $clog2(VEC_LEN);
  localparam int OUT_W = ACC_W + 1;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [LANES*DW-1:0] a_in = '0, w_in = '0;
  logic in_ready, out_valid, busy;
  logic [OUT_W-1:0] out;
  int cyc = 0, c0 = 0, tests = 0, fails = 0;
  logic [DW-1:0] ae [VEC_LEN], we [VEC_LEN];
  logic [DW-1:0] pad_a = '0, pad_w = '0;

  mac_seq #(.DW(DW), .VEC_LEN(VEC_LEN), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .w_in(w_in), .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint elem(input logic [DW-1:0] v);
    longint m = longint'(v[DW-2:0]);
    return v[DW-1] ? -m : m;
  endfunction

  // Dot product as plain signed arithmetic, then converted to the output encoding
  function automatic logic [OUT_W-1:0] model();
    longint s = 0;
    for (int i = 0; i < VEC_LEN; i++) s += elem(ae[i]) * elem(we[i]);
    if (s > 0) return {1'b0, ACC_W'(s)};
`ifdef MAC_SEQ_RELU_EN
    return '0;
`else
    if (s < 0) return {1'b1, ACC_W'(-s)};
    return '0;
`endif
  endfunction

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] w);
    for (int i = 0; i < VEC_LEN; i++) begin ae[i] = a; we[i] = w; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < VEC_LEN; i++) begin ae[i] = DW'($urandom); we[i] = DW'($urandom); end
    pad_a = DW'($urandom);
    pad_w = DW'($urandom);
  endtask

  task automatic do_start();
    start = 1;
    c0 = cyc;
    tick();
    start = 0;
    check("start_ready", in_ready, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic feed(input int gap_pct, input bit pulse_start, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        in_valid = 0;
        a_in = LANES*DW'($urandom);
        tick();
        check("gap_ready", in_ready, 1);
        check("gap_cnt", 64'(dut.beat_cnt), 64'(b));
      end
      for (int k = 0; k < LANES; k++) begin
        a_in[k*DW +: DW] = (b * LANES + k < VEC_LEN) ? ae[b*LANES+k] : pad_a;
        w_in[k*DW +: DW] = (b * LANES + k < VEC_LEN) ? we[b*LANES+k] : pad_w;
      end
      in_valid = 1;
      start = pulse_start && b == 3;
      tick();
      start = 0;
    end
    in_valid = 0;
  endtask

  task automatic check_result(input string tag, input int hold, input bit start_on_exit);
    logic [OUT_W-1:0] exp = model();
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out, exp);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_out", out, exp);
    end
    out_ready = 1;
    start = start_on_exit;
    tick();
    out_ready = 0;
    start = 0;
    check("exit_valid", out_valid, 0);
    check("exit_busy", busy, 0);
    if (start_on_exit) begin
      tick();
      check("exit_start_ignored", busy, 0);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    rst_n = 1;
    tick();
    check("idle_ready", in_ready, 0);

    fill(8'h01, 8'h01);
    do_start();
    feed(0, 0, BEATS);
    check("latency", 64'(cyc - c0), 64'(BEATS + 1));
    check("ones_exact", out, {1'b0, ACC_W'(62)});
    check_result("ones", 0, 0);

    fill(8'h7F, 8'hFF);
    do_start();
    feed(0, 0, BEATS);
`ifdef MAC_SEQ_RELU_EN
    check("maxneg_exact", out, 0);
`else
    check("maxneg_exact", out, {1'b1, ACC_W'(999998)});
`endif
    check_result("maxneg", 0, 1);

    fill(8'h00, 8'h00);
    pad_a = 8'h7F;
    pad_w = 8'h7F;
    do_start();
    feed(0, 0, BEATS);
    check_result("padding", 0, 0);

    for (int i = 0; i < VEC_LEN; i++) begin ae[i] = 8'h02; we[i] = i < 31 ? 8'h03 : 8'h83; end
    do_start();
    feed(0, 0, BEATS);
    check("cancel_exact", out, 0);
    check_result("cancel", 0, 0);

    for (int r = 0; r < 5; r++) begin
      fill_rand();
      do_start();
      feed(40, r[0], BEATS);
      check_result("rand", r == 2 ? 5 : r, r[1]);
    end

    fill_rand();
    do_start();
    feed(0, 0, 8);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    check("abort_valid", out_valid, 0);
    fill(8'h01, 8'h01);
    do_start();
    feed(20, 0, BEATS);
    check("fresh_exact", out, {1'b0, ACC_W'(62)});
    check_result("fresh", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
